// File: rtl/bcd_time_pkg.sv
// Shared BCD types, time limits and helpers for the timekeeper.
package bcd_time_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

  // Valid BCD ordering matches binary ordering, so a plain compare bounds the value.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max_bcd);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_bcd);
  endfunction

  // Binary 0..19 to packed BCD.
  function automatic logic [7:0] small_bin_to_bcd(input logic [4:0] b);
    if (b >= 5'd10) return {4'd1, 4'(b - 5'd10)};
    return {4'd0, 4'(b)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter, up/down, with combinational carry/borrow for same-edge cascading.
module bcd_mod_counter
  import bcd_time_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  localparam bcd_digit_t MAX_TENS = 4'((MODULUS - 1) / 10);
  localparam bcd_digit_t MAX_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};

  bcd_digit_t tens, ones;
  logic [7:0] next_val;
  logic       at_max, at_min;

  assign tens   = value[7:4];
  assign ones   = value[3:0];
  assign at_max = (value == MAX_BCD);
  assign at_min = (value == 8'h00);
  assign carry  = en & (dir ? at_min : at_max);

  always_comb begin
    next_val = value;
    if (dir) begin
      if (at_min)              next_val = MAX_BCD;
      else if (ones == 4'd0)   next_val = {tens - 4'd1, 4'd9};
      else                     next_val = {tens, ones - 4'd1};
    end else begin
      if (at_max)              next_val = 8'h00;
      else if (ones == 4'd9)   next_val = {tens + 4'd1, 4'd0};
      else                     next_val = {tens, ones + 4'd1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      value <= 8'h00;
    else if (load)  value <= load_val;
    else if (en)    value <= next_val;
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// 24-hour BCD time-of-day counter with tick prescaler, preset load and 12-hour display option.
module bcd_timekeeper
  import bcd_time_pkg::*;
#(
  parameter int WITH_SECONDS = 1,
  parameter int TICK_DIV     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       dir,
  input  logic       mode12,
  input  logic       load,
  input  logic [7:0] load_h,
  input  logic [7:0] load_m,
  input  logic [7:0] load_s,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       pm,
  output logic       day_carry,
  output logic       load_err
);

  localparam bit         HAS_SEC    = (WITH_SECONDS != 0);
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc;
  logic        load_ok, advance, min_en, min_carry, hour_carry;
  logic [7:0]  hour_24;
  logic [4:0]  hour_bin, hour12_bin;

  assign load_ok = load & bcd_valid(load_h, HOUR_MAX) & bcd_valid(load_m, MIN_MAX)
                 & (!HAS_SEC || bcd_valid(load_s, SEC_MAX));
  // A load cycle swallows any tick, whether or not the load is accepted.
  assign advance = tick & ~load & (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              presc <= 16'd0;
    else if (load_ok)       presc <= 16'd0;
    else if (tick & ~load)  presc <= advance ? 16'd0 : presc + 16'd1;
  end

  generate
    if (HAS_SEC) begin : g_sec
      logic sec_carry;
      bcd_mod_counter #(.MODULUS(60)) u_sec (
        .clk(clk), .reset(reset), .en(advance), .dir(dir), .load(load_ok),
        .load_val(load_s), .value(second), .carry(sec_carry)
      );
      assign min_en = sec_carry;
    end else begin : g_nosec
      logic unused_load_s;
      assign unused_load_s = ^load_s;
      assign second        = 8'h00;
      assign min_en        = advance;
    end
  endgenerate

  bcd_mod_counter #(.MODULUS(60)) u_min (
    .clk(clk), .reset(reset), .en(min_en), .dir(dir), .load(load_ok),
    .load_val(load_m), .value(minute), .carry(min_carry)
  );

  bcd_mod_counter #(.MODULUS(24)) u_hour (
    .clk(clk), .reset(reset), .en(min_carry), .dir(dir), .load(load_ok),
    .load_val(load_h), .value(hour_24), .carry(hour_carry)
  );

  // day_carry needs an advance (no load) while load_err needs a load, so they never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      day_carry <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      day_carry <= hour_carry;
      load_err  <= load & ~load_ok;
    end
  end

  assign hour_bin = 5'(hour_24[7:4]) * 5'd10 + 5'(hour_24[3:0]);
  assign pm       = (hour_bin >= 5'd12);

  always_comb begin
    hour12_bin = hour_bin;
    if (hour_bin == 5'd0)       hour12_bin = 5'd12;
    else if (hour_bin > 5'd12)  hour12_bin = hour_bin - 5'd12;
  end

  assign hour = mode12 ? small_bin_to_bcd(hour12_bin) : hour_24;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Bench for bcd_timekeeper: three parameterisations against a seconds-of-day reference model.
module tb_bcd_timekeeper;

  logic clk = 1'b0;
  logic reset, tick, dir, mode12, load;
  logic [7:0] load_h, load_m, load_s;

  logic [7:0] hour_o[3], minute_o[3], second_o[3];
  logic       pm_o[3], dc_o[3], err_o[3];

  int checks = 0;
  int errors = 0;

  // Instance 0: TICK_DIV=1 with seconds; 1: TICK_DIV=4 with seconds; 2: TICK_DIV=1 without seconds.
  bcd_timekeeper #(.WITH_SECONDS(1), .TICK_DIV(1)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .mode12(mode12), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .hour(hour_o[0]), .minute(minute_o[0]), .second(second_o[0]),
    .pm(pm_o[0]), .day_carry(dc_o[0]), .load_err(err_o[0]));

  bcd_timekeeper #(.WITH_SECONDS(1), .TICK_DIV(4)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .mode12(mode12), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .hour(hour_o[1]), .minute(minute_o[1]), .second(second_o[1]),
    .pm(pm_o[1]), .day_carry(dc_o[1]), .load_err(err_o[1]));

  bcd_timekeeper #(.WITH_SECONDS(0), .TICK_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .mode12(mode12), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .hour(hour_o[2]), .minute(minute_o[2]), .second(second_o[2]),
    .pm(pm_o[2]), .day_carry(dc_o[2]), .load_err(err_o[2]));

  always #5 clk = ~clk;

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  int div_a[3] = '{1, 4, 1};
  int ws_a[3]  = '{1, 1, 0};
  int mt[3], mp[3];
  bit mdc[3], merr[3];

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int bcd_num(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit field_ok(input logic [7:0] v, input int max);
    return (v[7:4] <= 9) && (v[3:0] <= 9) && (bcd_num(v) <= max);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mt[k] = 0; mp[k] = 0; mdc[k] = 0; merr[k] = 0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int unit;
      bit ok;
      unit = (ws_a[k] != 0) ? 1 : 60;
      mdc[k] = 0;
      merr[k] = 0;
      if (load) begin
        ok = field_ok(load_h, 23) && field_ok(load_m, 59) && (ws_a[k] == 0 || field_ok(load_s, 59));
        if (ok) begin
          mt[k] = bcd_num(load_h) * 3600 + bcd_num(load_m) * 60
                + ((ws_a[k] != 0) ? bcd_num(load_s) : 0);
          mp[k] = 0;
        end else merr[k] = 1;
      end else if (tick) begin
        mp[k]++;
        if (mp[k] == div_a[k]) begin
          mp[k] = 0;
          if (dir) begin
            if (mt[k] == 0) begin mt[k] = 86400 - unit; mdc[k] = 1; end
            else mt[k] -= unit;
          end else begin
            mt[k] += unit;
            if (mt[k] >= 86400) begin mt[k] = 0; mdc[k] = 1; end
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input int k, input string tag);
    int h, hd;
    h  = mt[k] / 3600;
    hd = h;
    if (mode12) hd = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    check($sformatf("%s%0d_hour", tag, k), hour_o[k], to_bcd(hd));
    check($sformatf("%s%0d_minute", tag, k), minute_o[k], to_bcd((mt[k] / 60) % 60));
    check($sformatf("%s%0d_second", tag, k), second_o[k], (ws_a[k] != 0) ? to_bcd(mt[k] % 60) : 8'h00);
    check($sformatf("%s%0d_pm", tag, k), {7'd0, pm_o[k]}, {7'd0, h >= 12});
    check($sformatf("%s%0d_day_carry", tag, k), {7'd0, dc_o[k]}, {7'd0, mdc[k]});
    check($sformatf("%s%0d_load_err", tag, k), {7'd0, err_o[k]}, {7'd0, merr[k]});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    tick = 0; load = 0; load_h = 8'h00; load_m = 8'h00; load_s = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_time(input int k, input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, "_hour"}, hour_o[k], h);
    check({tag, "_minute"}, minute_o[k], m);
    check({tag, "_second"}, second_o[k], s);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] lh, lm, ls;
    logic       tk, dr, m12;
    logic [7:0] eh, em, es;
    logic       epm, edc, eerr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    reset = 1'b1; dir = 0; mode12 = 0;
    idle_inputs();

    // Reset state, including 12-hour reading of midnight.
    #2;
    check_time(0, "rst", 8'h00, 8'h00, 8'h00);
    check("rst_pm", {7'd0, pm_o[0]}, 8'h00);
    check("rst_day_carry", {7'd0, dc_o[0]}, 8'h00);
    check("rst_load_err", {7'd0, err_o[0]}, 8'h00);
    mode12 = 1; #1;
    check("rst_hour12", hour_o[0], 8'h12);
    mode12 = 0;
    do_reset();

    //          ld  lh     lm     ls     tk dr m12  eh     em     es     pm dc err
    vecs[0]  = '{1, 8'h23, 8'h59, 8'h58, 0, 0, 0, 8'h23, 8'h59, 8'h58, 1, 0, 0};
    vecs[1]  = '{0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h23, 8'h59, 8'h59, 1, 0, 0};
    vecs[2]  = '{0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0};
    vecs[3]  = '{0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0};
    vecs[4]  = '{1, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0};
    vecs[5]  = '{0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 8'h23, 8'h59, 8'h59, 1, 1, 0};
    vecs[6]  = '{0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h23, 8'h59, 8'h59, 1, 0, 0};
    vecs[7]  = '{1, 8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h23, 8'h59, 8'h59, 1, 0, 1};
    vecs[8]  = '{0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h23, 8'h59, 8'h59, 1, 0, 0};
    vecs[9]  = '{1, 8'h00, 8'h5A, 8'h00, 0, 0, 0, 8'h23, 8'h59, 8'h59, 1, 0, 1};
    vecs[10] = '{1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h12, 8'h00, 8'h00, 0, 0, 0};
    vecs[11] = '{1, 8'h12, 8'h00, 8'h00, 0, 0, 1, 8'h12, 8'h00, 8'h00, 1, 0, 0};
    vecs[12] = '{1, 8'h13, 8'h00, 8'h00, 0, 0, 1, 8'h01, 8'h00, 8'h00, 1, 0, 0};
    vecs[13] = '{1, 8'h23, 8'h05, 8'h09, 0, 0, 1, 8'h11, 8'h05, 8'h09, 1, 0, 0};
    vecs[14] = '{1, 8'h00, 8'h59, 8'h59, 1, 0, 0, 8'h00, 8'h59, 8'h59, 0, 0, 0};
    vecs[15] = '{0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 0};
    vecs[16] = '{1, 8'h01, 8'h00, 8'h60, 1, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 1};
    vecs[17] = '{1, 8'h1A, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h00, 8'h00, 0, 0, 1};

    for (int i = 0; i < 18; i++) begin
      load = vecs[i].ld; load_h = vecs[i].lh; load_m = vecs[i].lm; load_s = vecs[i].ls;
      tick = vecs[i].tk; dir = vecs[i].dr; mode12 = vecs[i].m12;
      step();
      check_time(0, $sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es);
      check($sformatf("vec%0d_pm", i), {7'd0, pm_o[0]}, {7'd0, vecs[i].epm});
      check($sformatf("vec%0d_day_carry", i), {7'd0, dc_o[0]}, {7'd0, vecs[i].edc});
      check($sformatf("vec%0d_load_err", i), {7'd0, err_o[0]}, {7'd0, vecs[i].eerr});
    end

    // Prescaler with TICK_DIV=4: ten ticks from reset, then a load that swallows a tick.
    idle_inputs(); dir = 0; mode12 = 0;
    do_reset();
    tick = 1;
    for (int i = 0; i < 10; i++) step();
    check_time(1, "div4_ten_ticks", 8'h00, 8'h00, 8'h02);
    load = 1; load_h = 8'h10; load_m = 8'h20; load_s = 8'h30;
    step();
    check_time(1, "div4_load", 8'h10, 8'h20, 8'h30);
    load = 0;
    for (int i = 0; i < 3; i++) step();
    check_time(1, "div4_three_after_load", 8'h10, 8'h20, 8'h30);
    step();
    check_time(1, "div4_fourth_after_load", 8'h10, 8'h20, 8'h31);
    step(); step();
    dir = 1;
    step(); step();
    check_time(1, "div4_dir_change_keeps_prescaler", 8'h10, 8'h20, 8'h30);

    // Minutes-only variant and asynchronous reset between edges.
    idle_inputs(); dir = 0;
    load = 1; load_h = 8'h09; load_m = 8'h59; load_s = 8'h77;
    step();
    load = 0; tick = 1;
    step();
    check_time(2, "nosec_rollover", 8'h10, 8'h00, 8'h00);
    tick = 0;
    #2;
    reset = 1'b1;
    mode12 = 1;
    #1;
    check("async_rst_hour12", hour_o[2], 8'h12);
    check("async_rst_minute", minute_o[2], 8'h00);
    check("async_rst_pm", {7'd0, pm_o[2]}, 8'h00);
    check("async_rst_dut0_second", second_o[0], 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mode12 = 0;

    // Randomised run against the model on all three instances.
    for (int c = 0; c < 2500; c++) begin
      int r;
      tick   = ($urandom_range(0, 9) < 6);
      dir    = $urandom_range(0, 1);
      mode12 = $urandom_range(0, 1);
      r      = $urandom_range(0, 99);
      load   = (r < 6);
      if ($urandom_range(0, 3) == 0) begin
        load_h = 8'($urandom_range(0, 255));
        load_m = 8'($urandom_range(0, 255));
        load_s = 8'($urandom_range(0, 255));
      end else begin
        load_h = to_bcd($urandom_range(0, 23));
        load_m = to_bcd($urandom_range(0, 59));
        load_s = to_bcd($urandom_range(0, 59));
        if ($urandom_range(0, 1) == 1) begin
          load_h = 8'h23; load_m = 8'h59;
        end
      end
      step();
      for (int k = 0; k < 3; k++) check_model(k, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
